// File: rtl/reg_xfer_sequencer.sv
// Transfer sequencer for a latch/enable register bank: reads a source register
// (or takes an immediate) and writes it to a destination. Optional XFER_COUNT_EN adds xfer_count.
module reg_xfer_sequencer #(
    parameter int NUM_REGS = 4,
    parameter int DATA_W   = 8,
    parameter int SEL_W    = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [SEL_W-1:0]             src_sel,
    input  logic [SEL_W-1:0]             dst_sel,
    input  logic                         src_imm,
    input  logic [DATA_W-1:0]            imm_data,
    input  logic [NUM_REGS*DATA_W-1:0]   reg_rd_data,
    output logic [NUM_REGS-1:0]          reg_en,
    output logic [NUM_REGS-1:0]          reg_latch,
    output logic [DATA_W-1:0]            bus_data,
    output logic                         done,
`ifdef XFER_COUNT_EN
    output logic [15:0]                  xfer_count,
`endif
    output logic                         err
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t               state_q;
    logic [SEL_W-1:0]     src_q;
    logic [SEL_W-1:0]     dst_q;
    logic                 imm_sel_q;
    logic [DATA_W-1:0]    imm_q;
    logic [NUM_REGS-1:0]  en_q;
    logic [NUM_REGS-1:0]  latch_q;
    logic [DATA_W-1:0]    bus_q;
    logic                 done_q;
    logic                 err_q;
    logic [DATA_W-1:0]    rd_mux;
    logic [DATA_W-1:0]    wr_val_d;
    logic                 accept;
    logic                 bad_req;

    function automatic logic [NUM_REGS-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [NUM_REGS-1:0] oh;
        oh = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            oh[i] = (idx == SEL_W'(i));
        end
        return oh;
    endfunction

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (src_q == SEL_W'(i)) begin
                rd_mux = reg_rd_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign wr_val_d  = imm_sel_q ? imm_q : rd_mux;
    // The bus is live only while the destination is capturing; otherwise it holds.
    assign bus_data  = (state_q == WRITE) ? wr_val_d : bus_q;
    assign req_ready = (state_q == IDLE) && !rst;
    assign accept    = req_valid && req_ready;
    assign bad_req   = (int'(dst_sel) >= NUM_REGS) ||
                       (!src_imm && (int'(src_sel) >= NUM_REGS));

    assign reg_en    = en_q;
    assign reg_latch = latch_q;
    assign done      = done_q;
    assign err       = err_q;

`ifdef XFER_COUNT_EN
    logic [15:0] count_q;
    logic [15:0] count_d;
    assign count_d    = count_q + 16'd1;
    assign xfer_count = count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (state_q == WRITE) begin
            count_q <= count_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            src_q     <= '0;
            dst_q     <= '0;
            imm_sel_q <= 1'b0;
            imm_q     <= '0;
            en_q      <= '0;
            latch_q   <= '0;
            bus_q     <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            en_q    <= '0;
            latch_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        src_q     <= src_sel;
                        dst_q     <= dst_sel;
                        imm_sel_q <= src_imm;
                        imm_q     <= imm_data;
                        if (bad_req) begin
                            err_q <= 1'b1;
                        end else if (src_imm) begin
                            state_q <= WRITE;
                            latch_q <= onehot(dst_sel);
                        end else begin
                            state_q <= READ;
                            en_q    <= onehot(src_sel);
                        end
                    end
                end
                READ: begin
                    state_q <= WRITE;
                    latch_q <= onehot(dst_q);
                end
                WRITE: begin
                    state_q <= DONE;
                    done_q  <= 1'b1;
                    bus_q   <= wr_val_d;
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_xfer_sequencer.sv
// Bench for reg_xfer_sequencer: bank model, timeline reference model, directed and random stimulus.
module tb_reg_xfer_sequencer;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int SW = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           req_valid;
    logic           req_ready;
    logic [SW-1:0]  src_sel;
    logic [SW-1:0]  dst_sel;
    logic           src_imm;
    logic [DW-1:0]  imm_data;
    logic [NR*DW-1:0] reg_rd_data;
    logic [NR-1:0]  reg_en;
    logic [NR-1:0]  reg_latch;
    logic [DW-1:0]  bus_data;
    logic           done;
    logic           err;
`ifdef XFER_COUNT_EN
    logic [15:0]    xfer_count;
`endif

    always #5 clk = ~clk;

    reg_xfer_sequencer #(.NUM_REGS(NR), .DATA_W(DW), .SEL_W(SW)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .src_sel(src_sel), .dst_sel(dst_sel), .src_imm(src_imm), .imm_data(imm_data),
        .reg_rd_data(reg_rd_data), .reg_en(reg_en), .reg_latch(reg_latch),
        .bus_data(bus_data), .done(done),
`ifdef XFER_COUNT_EN
        .xfer_count(xfer_count),
`endif
        .err(err)
    );

    // Register bank: latch captures bus_data, en refreshes the read-out copy.
    logic          bank_init;
    logic [DW-1:0] bank_mem [NR];
    logic [DW-1:0] bank_out [NR];

    always @(posedge clk) begin
        for (int i = 0; i < NR; i++) begin
            if (bank_init) begin
                bank_mem[i] <= '0;
                bank_out[i] <= '0;
            end else begin
                if (reg_latch[i]) bank_mem[i] <= bus_data;
                if (reg_en[i])    bank_out[i] <= bank_mem[i];
            end
        end
    end

    always_comb begin
        reg_rd_data = '0;
        for (int i = 0; i < NR; i++) reg_rd_data[i*DW +: DW] = bank_out[i];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Expected-output timeline, 8 cycles deep, indexed by cycle number.
    logic [NR-1:0] r_en  [8];
    logic [NR-1:0] r_lat [8];
    logic [DW-1:0] r_bus [8];
    logic [1:0]    r_dst [8];
    logic          r_bv  [8];
    logic          r_done[8];
    logic          r_err [8];
    logic [DW-1:0] model_mem [NR] = '{8'h00, 8'h00, 8'h00, 8'h00};
    logic [DW-1:0] bus_hold = '0;
    int            free_at = 0;
    logic          will_accept = 1'b0;
    int            last_acc = -1;
    int            last_done_cyc = -1;
    int            last_err_cyc = -1;
    int            last_en_cyc = -1;
    int            last_latch_cyc = -1;
    logic [NR-1:0] last_en = '0;
    logic [NR-1:0] last_latch = '0;
    logic [DW-1:0] last_bus = '0;
`ifdef XFER_COUNT_EN
    logic [15:0]   exp_cnt = '0;
`endif

    int pin_id;
    int p_acc;
    int sv_latch;
    int sv_done;

    always @(negedge clk) begin
        int s;
        int t;
        logic e_rdy;
        logic [DW-1:0] e_bus;
        s = cyc % 8;
        e_rdy = !rst && (cyc >= free_at);
        e_bus = r_bv[s] ? r_bus[s] : bus_hold;
        if (cyc >= 1) begin
`ifdef XFER_COUNT_EN
            if (r_done[s]) exp_cnt = exp_cnt + 16'd1;
            check("xfer_count", 32'(xfer_count), 32'(exp_cnt));
`endif
            check("req_ready", 32'(req_ready), 32'(e_rdy));
            check("reg_en",    32'(reg_en),    32'(r_en[s]));
            check("reg_latch", 32'(reg_latch), 32'(r_lat[s]));
            check("bus_data",  32'(bus_data),  32'(e_bus));
            check("done",      32'(done),      32'(r_done[s]));
            check("err",       32'(err),       32'(r_err[s]));
            if (r_bv[s]) begin
                bus_hold = r_bus[s];
                model_mem[r_dst[s]] = r_bus[s];
            end
            if (done) last_done_cyc = cyc;
            if (err)  last_err_cyc = cyc;
            if (|reg_en) begin last_en = reg_en; last_en_cyc = cyc; end
            if (|reg_latch) begin
                last_latch = reg_latch; last_latch_cyc = cyc; last_bus = bus_data;
            end
        end
        r_en[s] = '0; r_lat[s] = '0; r_bus[s] = '0; r_dst[s] = '0;
        r_bv[s] = 1'b0; r_done[s] = 1'b0; r_err[s] = 1'b0;

        // Predict what the coming edge does.
        will_accept = 1'b0;
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                r_en[i] = '0; r_lat[i] = '0; r_bus[i] = '0; r_dst[i] = '0;
                r_bv[i] = 1'b0; r_done[i] = 1'b0; r_err[i] = 1'b0;
            end
            bus_hold = '0;
            free_at = cyc + 1;
`ifdef XFER_COUNT_EN
            exp_cnt = '0;
`endif
        end else if (req_valid && e_rdy) begin
            will_accept = 1'b1;
            last_acc = cyc;
            if (dst_sel >= 4'(NR) || (!src_imm && src_sel >= 4'(NR))) begin
                r_err[(cyc + 1) % 8] = 1'b1;
            end else begin
                t = src_imm ? cyc + 1 : cyc + 2;
                if (!src_imm) r_en[(cyc + 1) % 8] = 4'b0001 << src_sel[1:0];
                r_lat[t % 8] = 4'b0001 << dst_sel[1:0];
                r_bus[t % 8] = src_imm ? imm_data : model_mem[src_sel[1:0]];
                r_dst[t % 8] = dst_sel[1:0];
                r_bv[t % 8]  = 1'b1;
                r_done[(t + 1) % 8] = 1'b1;
                free_at = t + 2;
            end
        end

        case (pin_id)
            1: begin
                check("rst_reg_en",    32'(reg_en),    32'h0);
                check("rst_reg_latch", 32'(reg_latch), 32'h0);
                check("rst_bus_data",  32'(bus_data),  32'h00);
                check("rst_done",      32'(done),      32'h0);
                check("rst_err",       32'(err),       32'h0);
                check("rst_ready",     32'(req_ready), 32'h1);
            end
            2: begin
                check("imm_latch",     32'(last_latch), 32'b0100);
                check("imm_bus",       32'(last_bus),   32'hA5);
                check("imm_latch_cyc", 32'(last_latch_cyc - p_acc), 32'd1);
                check("imm_done_lat",  32'(last_done_cyc - p_acc),  32'd2);
                check("imm_bank_r2",   32'(bank_mem[2]), 32'hA5);
            end
            3: begin
                check("reg_en_val",    32'(last_en),    32'b0010);
                check("reg_en_cyc",    32'(last_en_cyc - p_acc),    32'd1);
                check("reg_latch_val", 32'(last_latch), 32'b1000);
                check("reg_bus",       32'(last_bus),   32'h3C);
                check("reg_done_lat",  32'(last_done_cyc - p_acc),  32'd3);
                check("reg_bank_r3",   32'(bank_mem[3]), 32'h3C);
            end
            4, 5: begin
                check("err_cyc",       32'(last_err_cyc - p_acc), 32'd1);
                check("err_no_latch",  32'(last_latch_cyc), 32'(sv_latch));
                check("err_no_done",   32'(last_done_cyc),  32'(sv_done));
            end
            6: begin
                check("abort_en_cyc",  32'(last_en_cyc - p_acc), 32'd1);
                check("abort_no_latch", 32'(last_latch_cyc), 32'(sv_latch));
                check("abort_no_done", 32'(last_done_cyc),  32'(sv_done));
                check("abort_bank_r1", 32'(bank_mem[1]), 32'h11);
            end
            9: begin
                for (int i = 0; i < NR; i++) check("bank_final", 32'(bank_mem[i]), 32'(model_mem[i]));
            end
            99: check("accept_timeout", 32'h0, 32'h1);
            default: ;
        endcase
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pin(input int id);
        pin_id = id;
        @(posedge clk);
        #1;
        pin_id = 0;
    endtask

    task automatic send(input logic [SW-1:0] s, input logic [SW-1:0] d,
                        input logic im, input logic [DW-1:0] v);
        logic got;
        got = 1'b0;
        req_valid = 1'b1; src_sel = s; dst_sel = d; src_imm = im; imm_data = v;
        for (int n = 0; n < 20 && !got; n++) begin
            @(posedge clk);
            got = will_accept;
            #1;
        end
        req_valid = 1'b0;
        if (!got) pin(99);
    endtask

    initial begin
        rst = 1'b1; bank_init = 1'b1; req_valid = 1'b0; pin_id = 0;
        src_sel = '0; dst_sel = '0; src_imm = 1'b0; imm_data = '0;
        p_acc = 0; sv_latch = 0; sv_done = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; bank_init = 1'b0;
        pin(1);

        send(4'd0, 4'd2, 1'b1, 8'hA5); p_acc = last_acc; idle(4); pin(2);

        send(4'd0, 4'd1, 1'b1, 8'h3C); idle(4);
        send(4'd1, 4'd3, 1'b0, 8'h00); p_acc = last_acc; idle(5); pin(3);

        sv_latch = last_latch_cyc; sv_done = last_done_cyc;
        send(4'd0, 4'd5, 1'b1, 8'h77); p_acc = last_acc; idle(3); pin(4);
        send(4'd7, 4'd1, 1'b0, 8'h00); p_acc = last_acc; idle(3); pin(5);

        send(4'd0, 4'd1, 1'b1, 8'h11); idle(4);
        sv_latch = last_latch_cyc; sv_done = last_done_cyc;
        send(4'd0, 4'd1, 1'b0, 8'h00); p_acc = last_acc;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        idle(5); pin(6);

        repeat (3000) begin
            rst       = ($urandom_range(0, 79) == 0);
            req_valid = ($urandom_range(0, 3) != 0);
            src_sel   = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
            dst_sel   = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
            src_imm   = 1'($urandom_range(0, 1));
            imm_data  = 8'($urandom);
            @(posedge clk); #1;
        end
        rst = 1'b0; req_valid = 1'b0;
        idle(6); pin(9);
        idle(1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
